// File: rtl/fft_input_reorder.sv
// Serial-to-parallel input stage for the 8-point FFT: bit-reversed placement into ping-pong banks.
// Optional REORDER_LAST_CHECK_EN adds s_last_i / err_o framing check (report only).
module fft_input_reorder #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 50
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
`ifdef REORDER_LAST_CHECK_EN
  input  logic              s_last_i,
  output logic              err_o,
`endif
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o [N-1:0]
);

  localparam int unsigned      LOG2N   = $clog2(N);
  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = v[int'(LOG2N) - 1 - i];
    return r;
  endfunction

  logic [DATA_W-1:0] bank_q [2][N];
  logic [DATA_W-1:0] bank_d [2][N];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic              accept, take, last_cnt;

  // All outputs come straight from registers; no input-to-output path.
  always_comb begin
    s_ready_o = ~full_q[wr_bank_q];
    m_valid_o = full_q[rd_bank_q];
    for (int j = 0; j < int'(N); j++) m_data_o[j] = bank_q[rd_bank_q][j];
  end

  always_comb begin
    accept    = s_valid_i & s_ready_o;
    take      = m_valid_o & m_ready_i;
    last_cnt  = (wr_cnt_q == LastIdx);
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (take) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    // Write bank is never full on accept, so it cannot collide with the take above.
    if (accept) begin
      bank_d[wr_bank_q][bitrev(wr_cnt_q)] = s_data_i;
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (last_cnt) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < int'(N); j++) bank_q[b][j] <= '0;
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

`ifdef REORDER_LAST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = accept & (s_last_i != last_cnt);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule
